// File: rtl/uart_to_ram_pkg.sv
// Shared constants and types for the UART-to-packet-buffer receive path.
//   BYTE_LEN            width of one UART payload byte
//   PACKET_BUFFER_SIZE  packet buffer RAM depth in bytes
//   UART_CYCLES_PER_BIT clk cycles per UART bit (50 MHz / 115200 baud); the
//                       transmit-side uart_driver uses the same constant
// Types: word-level FSM states, bit-level receiver states, debug state struct.
package uart_to_ram_pkg;

  localparam int BYTE_LEN            = 8;
  localparam int PACKET_BUFFER_SIZE  = 256;
  localparam int UART_CYCLES_PER_BIT = 434;

  typedef enum logic {
    W_IDLE  = 1'b0,
    W_ARMED = 1'b1
  } word_state_e;

  // RX_PARITY is only ever entered when UART_RX_PARITY_EN is defined.
  typedef enum logic [2:0] {
    RX_WAIT_START = 3'd0,
    RX_START      = 3'd1,
    RX_DATA       = 3'd2,
    RX_PARITY     = 3'd3,
    RX_STOP       = 3'd4
  } rx_state_e;

  typedef struct packed {
    word_state_e word_state;
    rx_state_e   bit_state;
  } dbg_state_t;

endpackage

// File: rtl/uart_rx_driver.sv
// UART byte receiver: 2-flop synchroniser, start/data/(parity)/stop bit
// states and the bit-timing counters.
// Configuration macro: UART_RX_PARITY_EN (8E1 framing when defined, 8N1 otherwise).
// Ports:
//   clk        in   system clock
//   reset      in   synchronous, active-high
//   en         in   receiver runs only while high; low holds it in RX_WAIT_START
//   rxd        in   raw asynchronous UART line (idle high)
//   data       out  last good byte, valid while outclk is high
//   outclk     out  one-cycle pulse, the cycle after a good stop sample
//   frame_err  out  one-cycle pulse, the cycle after a bad stop sample / parity
//   dbg_state  out  current bit-level state
module uart_rx_driver
  import uart_to_ram_pkg::*;
#(
  parameter int CYCLES_PER_BIT = UART_CYCLES_PER_BIT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic                rxd,
  output logic [BYTE_LEN-1:0] data,
  output logic                outclk,
  output logic                frame_err,
  output rx_state_e           dbg_state
);

  localparam int CW = $clog2(CYCLES_PER_BIT);

  logic          sync1_q, sync2_q, prev_q;
  rx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [BYTE_LEN-1:0] shreg_q, shreg_d;
  logic [BYTE_LEN-1:0] data_q, data_d;
  logic          par_err_q, par_err_d;
  logic          outclk_q, outclk_d;
  logic          ferr_q, ferr_d;

  logic fall, half_tick, last_tick;

  // prev_q trails the synchronised line by one cycle so a start edge is seen
  // in any state, including the cycle right after a stop sample.
  assign fall      = prev_q & ~sync2_q;
  assign half_tick = (cnt_q == CW'(CYCLES_PER_BIT / 2 - 1));
  assign last_tick = (cnt_q == CW'(CYCLES_PER_BIT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      prev_q    <= 1'b1;
      state_q   <= RX_WAIT_START;
      cnt_q     <= '0;
      bit_q     <= '0;
      shreg_q   <= '0;
      data_q    <= '0;
      par_err_q <= 1'b0;
      outclk_q  <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      sync1_q   <= rxd;
      sync2_q   <= sync1_q;
      prev_q    <= sync2_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shreg_q   <= shreg_d;
      data_q    <= data_d;
      par_err_q <= par_err_d;
      outclk_q  <= outclk_d;
      ferr_q    <= ferr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    bit_d     = bit_q;
    shreg_d   = shreg_q;
    data_d    = data_q;
    par_err_d = par_err_q;
    outclk_d  = 1'b0;
    ferr_d    = 1'b0;

    case (state_q)
      RX_WAIT_START: begin
        cnt_d     = '0;
        par_err_d = 1'b0;
        if (fall) state_d = RX_START;
      end
      RX_START: begin
        // Mid start bit: a line that is back high was a glitch.
        if (half_tick) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = sync2_q ? RX_WAIT_START : RX_DATA;
        end
      end
      RX_DATA: begin
        if (last_tick) begin
          cnt_d   = '0;
          shreg_d = {sync2_q, shreg_q[BYTE_LEN-1:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = RX_PARITY;
`else
            state_d = RX_STOP;
`endif
          end
        end
      end
      RX_PARITY: begin
        // Even parity: the parity bit equals the XOR of the data bits.
        if (last_tick) begin
          cnt_d     = '0;
          par_err_d = (sync2_q != ^shreg_q);
          state_d   = RX_STOP;
        end
      end
      RX_STOP: begin
        if (last_tick) begin
          cnt_d   = '0;
          state_d = RX_WAIT_START;
          if (sync2_q && !par_err_q) begin
            data_d   = shreg_q;
            outclk_d = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
        end
      end
      default: state_d = RX_WAIT_START;
    endcase

    if (!en) begin
      state_d = RX_WAIT_START;
      cnt_d   = '0;
    end
  end

  assign data      = data_q;
  assign outclk    = outclk_q;
  assign frame_err = ferr_q;
  assign dbg_state = state_q;

endmodule

// File: rtl/uart_to_ram.sv
// Receives UART bytes and writes them sequentially into the packet buffer RAM
// from write_start up to (excluding) write_end, addresses wrapping modulo RAM_SIZE.
// Configuration macro: UART_RX_PARITY_EN (8E1 framing in uart_rx_driver).
// Ports:
//   clk, reset         system clock; synchronous active-high reset
//   rxd                raw UART line
//   start              one-cycle pulse arming a transfer (ignored while busy)
//   write_start        first address, sampled with an accepted start
//   write_end          one past last address, sampled with an accepted start
//   ram_write_enable   one-cycle write strobe
//   ram_write_addr     write address, valid with the strobe
//   ram_write_val      received byte, valid with the strobe
//   busy               high from accepted start until done
//   done               one-cycle pulse after the last write (or for an empty range)
//   frame_err          one-cycle pulse on a rejected frame
//   dbg_state          word and bit FSM states
// Handshake: start is a single-cycle request accepted only while busy is low;
// ram_write_enable is a single-cycle strobe with no back-pressure.
module uart_to_ram
  import uart_to_ram_pkg::*;
#(
  parameter  int RAM_SIZE       = PACKET_BUFFER_SIZE,
  parameter  int CYCLES_PER_BIT = UART_CYCLES_PER_BIT,
  localparam int AW             = $clog2(RAM_SIZE)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                rxd,
  input  logic                start,
  input  logic [AW-1:0]       write_start,
  input  logic [AW-1:0]       write_end,
  output logic                ram_write_enable,
  output logic [AW-1:0]       ram_write_addr,
  output logic [BYTE_LEN-1:0] ram_write_val,
  output logic                busy,
  output logic                done,
  output logic                frame_err,
  output dbg_state_t          dbg_state
);

  word_state_e   state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] end_q, end_d;
  logic          done_q, done_d;

  logic [BYTE_LEN-1:0] rx_data;
  logic                rx_outclk, rx_ferr;
  rx_state_e           rx_state;
  logic                armed;
  logic [AW-1:0]       addr_inc;

  assign armed    = (state_q == W_ARMED);
  assign addr_inc = addr_q + 1'b1;

  uart_rx_driver #(
    .CYCLES_PER_BIT(CYCLES_PER_BIT)
  ) u_rx (
    .clk       (clk),
    .reset     (reset),
    .en        (armed),
    .rxd       (rxd),
    .data      (rx_data),
    .outclk    (rx_outclk),
    .frame_err (rx_ferr),
    .dbg_state (rx_state)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= W_IDLE;
      addr_q  <= '0;
      end_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      end_q   <= end_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    end_d   = end_q;
    done_d  = 1'b0;

    case (state_q)
      W_IDLE: begin
        if (start) begin
          addr_d = write_start;
          end_d  = write_end;
          // An empty range completes immediately without arming the receiver.
          if (write_start == write_end) done_d  = 1'b1;
          else                          state_d = W_ARMED;
        end
      end
      W_ARMED: begin
        if (rx_outclk) begin
          addr_d = addr_inc;
          // Only equality terminates, so ranges may wrap across address 0.
          if (addr_inc == end_q) begin
            done_d  = 1'b1;
            state_d = W_IDLE;
          end
        end
      end
      default: state_d = W_IDLE;
    endcase
  end

  assign ram_write_enable = armed & rx_outclk;
  assign ram_write_addr   = addr_q;
  assign ram_write_val    = rx_data;
  assign busy             = armed;
  assign done             = done_q;
  assign frame_err        = armed & rx_ferr;
  assign dbg_state        = '{word_state: state_q, bit_state: rx_state};

endmodule

// File: tb/tb_uart_to_ram.sv
module tb_uart_to_ram;
  import uart_to_ram_pkg::*;

  localparam int CPB = UART_CYCLES_PER_BIT;
  localparam int AW  = $clog2(PACKET_BUFFER_SIZE);
  localparam int EW  = 2 + AW + 8;
`ifdef UART_RX_PARITY_EN
  localparam bit PARITY = 1'b1;
`else
  localparam bit PARITY = 1'b0;
`endif
  localparam logic [1:0] K_WRITE = 2'd0;
  localparam logic [1:0] K_FERR  = 2'd1;
  localparam logic [1:0] K_DONE  = 2'd2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rxd = 1'b1;
  logic start = 1'b0;
  logic [AW-1:0] write_start = '0;
  logic [AW-1:0] write_end = '0;
  logic ram_write_enable;
  logic [AW-1:0] ram_write_addr;
  logic [7:0] ram_write_val;
  logic busy, done, frame_err;
  dbg_state_t dbg_state;

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  uart_to_ram dut (
    .clk              (clk),
    .reset            (reset),
    .rxd              (rxd),
    .start            (start),
    .write_start      (write_start),
    .write_end        (write_end),
    .ram_write_enable (ram_write_enable),
    .ram_write_addr   (ram_write_addr),
    .ram_write_val    (ram_write_val),
    .busy             (busy),
    .done             (done),
    .frame_err        (frame_err),
    .dbg_state        (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int errors = 0;
  int checks = 0;
  logic [EW-1:0] exp_q[$];
  logic [1:0] last_kind = K_DONE;
  int last_we_cyc = 0;
  logic prev_we = 1'b0;

  // Reference model: a transfer is a window [addr, end) walked modulo 2^AW.
  bit            m_armed = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [AW-1:0] m_end = '0;

  task automatic model_start(input logic [AW-1:0] ws, input logic [AW-1:0] we);
    if (m_armed) return;
    if (ws == we) exp_q.push_back({K_DONE, {AW{1'b0}}, 8'h00});
    else begin
      m_armed = 1'b1;
      m_addr  = ws;
      m_end   = we;
    end
  endtask

  task automatic model_frame(input logic [7:0] b, input bit good);
    if (!m_armed) return;
    if (!good) begin
      exp_q.push_back({K_FERR, {AW{1'b0}}, 8'h00});
      return;
    end
    exp_q.push_back({K_WRITE, m_addr, b});
    m_addr = m_addr + 1'b1;
    if (m_addr == m_end) begin
      exp_q.push_back({K_DONE, {AW{1'b0}}, 8'h00});
      m_armed = 1'b0;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic pop_cmp(input logic [1:0] k, input logic [AW-1:0] a, input logic [7:0] v,
                         input string nm);
    logic [EW-1:0] e;
    logic [EW-1:0] o;
    o = {k, a, v};
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: unexpected event %h at cycle %0d, expected none", nm, o, cyc);
    end else begin
      e = exp_q.pop_front();
      last_kind = e[EW-1 -: 2];
      if (e !== o) begin
        errors++;
        $display("FAIL %s: got kind/addr/val %h at cycle %0d, expected %h", nm, o, cyc, e);
      end
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!reset) begin
      if (ram_write_enable) begin
        checks++;
        if (prev_we) begin
          errors++;
          $display("FAIL strobe_gap: strobe at cycle %0d directly after another, expected a gap", cyc);
        end
        chk("busy_on_write", 32'(busy), 32'd1);
        pop_cmp(K_WRITE, ram_write_addr, ram_write_val, "write");
        last_we_cyc = cyc;
      end
      if (frame_err) pop_cmp(K_FERR, '0, 8'h00, "frame_err");
      if (done) begin
        if (last_kind == K_WRITE) chk("done_latency", 32'(cyc - last_we_cyc), 32'd1);
        chk("busy_at_done", 32'(busy), 32'd0);
        pop_cmp(K_DONE, '0, 8'h00, "done");
      end
    end
    prev_we <= ram_write_enable;
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit par_flip);
    rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (CPB) @(negedge clk);
    end
    if (PARITY) begin
      rxd = (^b) ^ par_flip;
      repeat (CPB) @(negedge clk);
    end
    rxd = stop_ok;
    repeat (CPB) @(negedge clk);
    rxd = 1'b1;
  endtask

  task automatic tx_byte(input logic [7:0] b, input bit stop_ok, input bit par_flip);
    model_frame(b, stop_ok && !(PARITY && par_flip));
    send_frame(b, stop_ok, par_flip);
    if (!stop_ok) idle(CPB);
  endtask

  task automatic do_start(input logic [AW-1:0] ws, input logic [AW-1:0] we);
    model_start(ws, we);
    @(negedge clk);
    write_start = ws;
    write_end   = we;
    start       = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'(m_armed));
  endtask

  task automatic wait_drain(input string nm);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 4 * CPB) begin
      @(negedge clk);
      t++;
    end
    repeat (20) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d expected events never seen, expected 0 outstanding", nm, exp_q.size());
      exp_q.delete();
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [AW-1:0] ws;
    logic [7:0] b;
    int n;
    int frames;
    bit bad;

    repeat (5) @(negedge clk);
    chk("reset_we", 32'(ram_write_enable), 32'd0);
    chk("reset_addr", 32'(ram_write_addr), 32'd0);
    chk("reset_val", 32'(ram_write_val), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_ferr", 32'(frame_err), 32'd0);
    reset = 1'b0;
    idle(10);

    // Three back-to-back bytes into addresses 0..2.
    do_start(AW'(0), AW'(3));
    idle(CPB);
    tx_byte(8'hA5, 1'b1, 1'b0);
    tx_byte(8'h3C, 1'b1, 1'b0);
    tx_byte(8'hFF, 1'b1, 1'b0);
    wait_drain("basic");

    // Bad stop bit, then a good byte at the same address.
    do_start(AW'(8), AW'(9));
    idle(CPB);
    tx_byte(8'h55, 1'b0, 1'b0);
    tx_byte(8'h12, 1'b1, 1'b0);
    wait_drain("stop_err");

    // Short low glitch is rejected.
    do_start(AW'(20), AW'(21));
    idle(CPB);
    rxd = 1'b0;
    repeat (100) @(negedge clk);
    idle(2 * CPB);
    tx_byte(8'h81, 1'b1, 1'b0);
    wait_drain("glitch");

    // Range wrapping across address 0.
    do_start(AW'(PACKET_BUFFER_SIZE - 1), AW'(1));
    idle(CPB);
    tx_byte(8'h01, 1'b1, 1'b0);
    tx_byte(8'h02, 1'b1, 1'b0);
    wait_drain("wrap");

    // Empty range completes with no write.
    do_start(AW'(60), AW'(60));
    wait_drain("empty");

    // Reset in the middle of data bit 4 aborts the transfer.
    do_start(AW'(30), AW'(40));
    idle(CPB);
    fork
      send_frame(8'h77, 1'b1, 1'b0);
      begin
        repeat (5 * CPB + CPB / 2) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("abort_we", 32'(ram_write_enable), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_ferr", 32'(frame_err), 32'd0);
        reset = 1'b0;
      end
    join
    m_armed = 1'b0;
    idle(CPB);
    tx_byte(8'h99, 1'b1, 1'b0);
    wait_drain("abort_idle");
    chk("idle_busy", 32'(busy), 32'd0);

`ifdef UART_RX_PARITY_EN
    do_start(AW'(50), AW'(52));
    idle(CPB);
    tx_byte(8'h03, 1'b1, 1'b0);
    tx_byte(8'h03, 1'b1, 1'b1);
    tx_byte(8'h03, 1'b1, 1'b0);
    wait_drain("parity");
`endif

    // Randomised short transfers with occasional bad stop bits.
    for (int r = 0; r < 2; r++) begin
      ws = AW'($urandom_range(0, PACKET_BUFFER_SIZE - 1));
      n  = $urandom_range(1, 2);
      do_start(ws, ws + AW'(n));
      idle($urandom_range(CPB, 2 * CPB));
      frames = 0;
      while (m_armed && frames < 5) begin
        b   = 8'($urandom);
        bad = ($urandom_range(0, 4) == 0);
        tx_byte(b, !bad, 1'b0);
        frames++;
      end
      wait_drain("random");
      if (m_armed) begin
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        m_armed = 1'b0;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
